// File: rtl/morse_encoder_pkg.sv
// rtl/morse_encoder_pkg.sv - shared Morse state encoding and unit-timing constants
package morse_encoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_LGAP,
        ST_DONE
    } state_t;

    // Also sets the decoder's shift-register width so both directions agree.
    localparam int MAX_SYM_DEF = 5;

    localparam logic [1:0] DOT_UNITS        = 2'd1;
    localparam logic [1:0] DASH_UNITS       = 2'd3;
    localparam logic [1:0] SYM_GAP_UNITS    = 2'd1;
    localparam logic [1:0] LETTER_GAP_UNITS = 2'd3;

endpackage

// File: rtl/morse_encoder_unit_timer.sv
// rtl/morse_encoder_unit_timer.sv - counts 1..3 Morse units of UNIT_TICKS cycles each
module unit_timer #(
    parameter int UNIT_TICKS = 5_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [1:0] units,
    output logic       expire
);

    localparam int TW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;

    logic [TW-1:0] tick_cnt;
    logic [1:0]    unit_cnt;
    logic          tick_last;

    assign tick_last = (tick_cnt == TW'(UNIT_TICKS - 1));
    assign expire    = run && tick_last && (unit_cnt == (units - 2'd1));

    // Clearing on expire restarts the count on every state entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            unit_cnt <= '0;
        end else if (!run || expire) begin
            tick_cnt <= '0;
            unit_cnt <= '0;
        end else if (tick_last) begin
            tick_cnt <= '0;
            unit_cnt <= unit_cnt + 2'd1;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/morse_encoder.sv
// rtl/morse_encoder.sv - keys one Morse letter with standard unit timing and start/busy/done handshake
module morse_encoder
    import morse_encoder_pkg::*;
#(
    parameter int UNIT_TICKS = 5_000_000,
    parameter int MAX_SYM    = MAX_SYM_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [MAX_SYM-1:0] pattern,
    input  logic [2:0]         length,
    output logic               key,
    output logic               busy,
    output logic               done,
    output logic [2:0]         sym_idx
);

    localparam logic [2:0] MAX_LEN = 3'(MAX_SYM);

    state_t             state;
    logic [MAX_SYM-1:0] pattern_q;
    logic [2:0]         len_q;
    logic [2:0]         len_clamped;
    logic [1:0]         units;
    logic               run;
    logic               expire;

    assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
    assign run = (state == ST_MARK) || (state == ST_SPACE) || (state == ST_LGAP);

    always_comb begin
        units = DOT_UNITS;
        unique case (state)
            ST_MARK:  units = pattern_q[sym_idx] ? DASH_UNITS : DOT_UNITS;
            ST_SPACE: units = SYM_GAP_UNITS;
            ST_LGAP:  units = LETTER_GAP_UNITS;
            default:  units = DOT_UNITS;
        endcase
    end

    unit_timer #(
        .UNIT_TICKS(UNIT_TICKS)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .run    (run),
        .units  (units),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            key       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sym_idx   <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    key     <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    sym_idx <= '0;
                    state   <= ST_IDLE;
                    if (start) begin
                        pattern_q <= pattern;
                        len_q     <= len_clamped;
                        // An empty letter still completes the handshake with a done pulse.
                        if (len_clamped == 3'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_MARK;
                            key   <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_MARK: begin
                    if (expire) begin
                        key   <= 1'b0;
                        state <= (sym_idx == (len_q - 3'd1)) ? ST_LGAP : ST_SPACE;
                    end
                end
                ST_SPACE: begin
                    if (expire) begin
                        key     <= 1'b1;
                        sym_idx <= sym_idx + 3'd1;
                        state   <= ST_MARK;
                    end
                end
                ST_LGAP: begin
                    if (expire) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        sym_idx <= '0;
                        state   <= ST_DONE;
                    end
                end
                default: begin
                    key   <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
// tb/tb_morse_encoder.sv - directed and random letters checked against a unit-timing expansion model
module tb_morse_encoder;

    localparam int U = 4;
    localparam int MS = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [MS-1:0] pattern;
    logic [2:0]    length;
    logic          key;
    logic          busy;
    logic          done;
    logic [2:0]    sym_idx;

    int tests = 0;
    int fails = 0;

    logic [5:0] exp_q[$];

    morse_encoder #(
        .UNIT_TICKS(U),
        .MAX_SYM   (MS)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .pattern(pattern),
        .length (length),
        .key    (key),
        .busy   (busy),
        .done   (done),
        .sym_idx(sym_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] obs();
        return {key, busy, done, sym_idx};
    endfunction

    task automatic check(input string tag, input logic [5:0] o, input logic [5:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed {key,busy,done,idx}=%b expected %b", tag, o, e);
        end
    endtask

    // Expected per-cycle outputs from cycle 1 onward, one entry per cycle.
    task automatic build(input logic [MS-1:0] pat, input logic [2:0] len);
        int n;
        exp_q.delete();
        n = (int'(len) > MS) ? MS : int'(len);
        for (int i = 0; i < n; i++) begin
            repeat ((pat[i] ? 3 : 1) * U) exp_q.push_back({1'b1, 1'b1, 1'b0, 3'(i)});
            if (i < n - 1) repeat (U) exp_q.push_back({1'b0, 1'b1, 1'b0, 3'(i)});
        end
        if (n > 0) repeat (3 * U) exp_q.push_back({1'b0, 1'b1, 1'b0, 3'(n - 1)});
        exp_q.push_back(6'b001000);
    endtask

    // Start must already be driven for cycle 0. Mid-letter inputs are scrambled
    // and start re-pulsed at cycle 6 to show they are ignored.
    task automatic run_letter(input string tag, input logic [MS-1:0] pat, input logic [2:0] len,
                              input bit b2b, input logic [MS-1:0] npat, input logic [2:0] nlen);
        build(pat, len);
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(negedge clk);
            check(tag, obs(), exp_q[k-1]);
            if (k == exp_q.size()) begin
                start   = b2b;
                pattern = npat;
                length  = nlen;
            end else begin
                start   = (k == 6) || ($urandom_range(0, 3) == 0);
                pattern = MS'($urandom);
                length  = 3'($urandom);
            end
        end
    endtask

    task automatic kick(input logic [MS-1:0] pat, input logic [2:0] len);
        @(negedge clk);
        check("idle_before_start", obs(), 6'b0);
        start   = 1'b1;
        pattern = pat;
        length  = len;
    endtask

    initial begin
        logic [MS-1:0] p, np;
        logic [2:0]    l, nl;
        bit            chain;

        reset_n = 1'b1;
        start   = 1'b0;
        pattern = '0;
        length  = '0;
        #2 reset_n = 1'b0;
        #1 check("reset_values", obs(), 6'b0);
        @(negedge clk);
        check("reset_held", obs(), 6'b0);
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_after_reset", obs(), 6'b0);
        end

        kick(5'b00010, 3'd2);
        run_letter("letter_A", 5'b00010, 3'd2, 1'b0, 5'd0, 3'd0);
        kick(5'b00000, 3'd1);
        run_letter("letter_E", 5'b00000, 3'd1, 1'b0, 5'd0, 3'd0);
        kick(5'b10110, 3'd0);
        run_letter("len_zero", 5'b10110, 3'd0, 1'b0, 5'd0, 3'd0);
        kick(5'b11111, 3'd7);
        run_letter("len_clamp", 5'b11111, 3'd7, 1'b0, 5'd0, 3'd0);
        kick(5'b00010, 3'd2);
        run_letter("b2b_first_A", 5'b00010, 3'd2, 1'b1, 5'b00000, 3'd1);
        run_letter("b2b_second_E", 5'b00000, 3'd1, 1'b0, 5'd0, 3'd0);

        kick(5'b00010, 3'd2);
        build(5'b00010, 3'd2);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("pre_reset_A", obs(), exp_q[k-1]);
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1 check("async_reset_mid_dash", obs(), 6'b0);
        repeat (3) begin
            @(negedge clk);
            check("reset_no_done", obs(), 6'b0);
        end
        reset_n = 1'b1;
        kick(5'b00000, 3'd1);
        run_letter("post_reset_E", 5'b00000, 3'd1, 1'b0, 5'd0, 3'd0);

        chain = 1'b0;
        p = MS'($urandom);
        l = 3'($urandom);
        for (int r = 0; r < 20; r++) begin
            if (!chain) kick(p, l);
            chain = ($urandom_range(0, 1) == 1);
            np = MS'($urandom);
            nl = 3'($urandom);
            run_letter("random_letter", p, l, chain, np, nl);
            p = np;
            l = nl;
        end
        @(negedge clk);
        check("final_idle", obs(), 6'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
